fc_output_collector: RTL and testbench
======================================

FC_OUTPUT_COLLECTOR -- requirements
Module: fc_output_collector

Interface
REQ-001 SHALL have parameter M, default 6: number of output words per frame (layer output vector length).
REQ-002 SHALL have parameter T, default 20: signed word width in bits.
REQ-003 SHALL define localparam A = $clog2(M): address/count width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 input_valid  input  1  upstream layer word valid; connects to the layer's output_valid.
REQ-007 input_ready  output  1  collector can accept a word; connects to the layer's output_ready.
REQ-008 input_data  input  T  signed word from the layer's output_data.
REQ-009 frame_done  output  1  a complete M-word frame is held in the buffer.
REQ-010 frame_ack  input  1  consumer releases the buffer; sampled only while frame_done=1.
REQ-011 word_count  output  A+1  number of words accepted in the current frame.
REQ-012 rd_addr  input  A  random-access read address into the buffer.
REQ-013 rd_data  output  T  signed registered read data.
REQ-014 argmax_idx  output  A  index of the largest word (present only with FC_ARGMAX_EN).
REQ-015 argmax_val  output  T  signed value of the largest word (present only with FC_ARGMAX_EN).

Function
REQ-016 SHALL implement a two-state FSM: COLLECT and HOLD.
REQ-017 In COLLECT: input_ready=1, frame_done=0; in HOLD: input_ready=0, frame_done=1; both decoded from the state register only, with no combinational path from input_valid.
REQ-018 A transfer occurs on a posedge where input_valid=1 and input_ready=1; word written to buf[word_count], word_count incremented.
REQ-019 Transfer with word_count=M-1: buffer written, word_count becomes M, state moves to HOLD on that edge; frame_done=1 the following cycle.
REQ-020 In HOLD: input_data ignored; buffer and word_count frozen.
REQ-021 In HOLD with frame_ack=1: state returns to COLLECT and word_count clears to 0 on that edge; buffer contents retained until overwritten.
REQ-022 frame_ack in COLLECT SHALL be ignored.
REQ-023 frame_ack and input_valid both high in HOLD: no word accepted that cycle; the first word of the next frame is accepted no earlier than the following cycle.
REQ-024 rd_data SHALL equal buf[rd_addr] one cycle after rd_addr is presented, in any state; rd_addr >= M returns 0.
REQ-025 A write and a read to the same address on the same edge SHALL return the old contents (read-before-write).
REQ-026 All buffer words are stored at full T-bit width, with no truncation or saturation.

Reset
REQ-027 While reset=0: state=COLLECT, word_count=0, all buf entries=0, rd_data=0, input_ready=1, frame_done=0.
REQ-028 With FC_ARGMAX_EN, reset SHALL also clear argmax_idx=0 and argmax_val=0.
REQ-029 Reset assertion mid-frame discards the partial frame; the first post-reset transfer is written to index 0.

Configuration
REQ-030 Macro FC_ARGMAX_EN defined: a running signed argmax updates on each transfer.
REQ-031 The word at index 0 initialises the tracker; a later word replaces it only if strictly greater, so ties keep the lower index.
REQ-032 argmax_idx/argmax_val SHALL be final when frame_done rises and hold through HOLD; they are reinitialised by the first transfer of the next frame.
REQ-033 Macro FC_ARGMAX_EN undefined: argmax_idx, argmax_val and the compare logic are absent; all other behaviour is identical.

Verification
REQ-034 Stream 5,-3,12,12,0,-7 with continuous valid -> frame_done=1 on the cycle after the 6th transfer, word_count=6; with FC_ARGMAX_EN, argmax_idx=2 and argmax_val=12.
REQ-035 After REQ-034, read addresses 0..5 -> rd_data = 5,-3,12,12,0,-7, each one cycle after its address; rd_addr=7 -> rd_data=0.
REQ-036 In HOLD, drive input_valid=1 with data 99 for 10 cycles -> input_ready=0, buffer unchanged; pulse frame_ack with valid still high -> no accept that cycle; word 99 is written to buf[0] the next cycle.
REQ-037 Inject idle gaps (input_valid=0 for 3 cycles) between words 2 and 3 -> same buffer contents as the gapless stream; frame_done timing follows the 6th transfer.
REQ-038 Assert reset=0 after 4 words, release, then send 6 words -1..-6 -> buf = -1..-6; with FC_ARGMAX_EN, argmax_idx=0 and argmax_val=-1.
REQ-039 All-negative frame with minimum value -524288 at index 5 and all others -1 -> with FC_ARGMAX_EN, argmax_idx=0 and argmax_val=-1 (signed compare, tie keeps lowest index).

Source files
------------

// File: rtl/fc_output_collector.sv
// Collects one M-word frame from an upstream FC layer into a random-access buffer.
// Optional running signed argmax over the frame is enabled by defining FC_ARGMAX_EN.
module fc_output_collector #(
    parameter int M = 6,
    parameter int T = 20,
    localparam int A = $clog2(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                input_valid,
    output logic                input_ready,
    input  logic signed [T-1:0] input_data,
    output logic                frame_done,
    input  logic                frame_ack,
    output logic [A:0]          word_count,
    input  logic [A-1:0]        rd_addr,
    output logic signed [T-1:0] rd_data
`ifdef FC_ARGMAX_EN
    ,
    output logic [A-1:0]        argmax_idx,
    output logic signed [T-1:0] argmax_val
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                wr_en;
    logic signed [T-1:0] mem_q [M];

    // Handshake outputs depend only on the state register.
    always_comb begin
        state_d     = state_q;
        input_ready = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            COLLECT: begin
                input_ready = 1'b1;
                if (input_valid && (word_count == (A+1)'(M - 1)))
                    state_d = HOLD;
            end
            HOLD: begin
                frame_done = 1'b1;
                if (frame_ack)
                    state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    assign wr_en = input_valid && input_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= COLLECT;
            word_count <= '0;
        end else begin
            state_q <= state_d;
            if (wr_en)
                word_count <= word_count + 1'b1;
            else if (state_q == HOLD && frame_ack)
                word_count <= '0;
        end
    end

    // Buffer write and registered read; non-blocking update gives read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < M; i++)
                mem_q[i] <= '0;
            rd_data <= '0;
        end else begin
            for (int i = 0; i < M; i++)
                if (wr_en && (word_count == (A+1)'(i)))
                    mem_q[i] <= input_data;
            rd_data <= '0;
            for (int i = 0; i < M; i++)
                if (rd_addr == A'(i))
                    rd_data <= mem_q[i];
        end
    end

`ifdef FC_ARGMAX_EN
    // Index 0 seeds the tracker; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            argmax_idx <= '0;
            argmax_val <= '0;
        end else if (wr_en && ((word_count == '0) || (input_data > argmax_val))) begin
            argmax_idx <= word_count[A-1:0];
            argmax_val <= input_data;
        end
    end
`endif

endmodule

// File: tb/tb_fc_output_collector.sv
// Scoreboard bench for fc_output_collector: stimulus queues expected frames/reads, a monitor checks them.
module tb_fc_output_collector;
    localparam int M = 6;
    localparam int T = 20;
    localparam int A = $clog2(M);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                input_valid = 1'b0;
    logic                input_ready;
    logic signed [T-1:0] input_data = '0;
    logic                frame_done;
    logic                frame_ack = 1'b0;
    logic [A:0]          word_count;
    logic [A-1:0]        rd_addr = '0;
    logic signed [T-1:0] rd_data;
`ifdef FC_ARGMAX_EN
    logic [A-1:0]        argmax_idx;
    logic signed [T-1:0] argmax_val;
`endif

    fc_output_collector #(.M(M), .T(T)) dut (
        .clk(clk),
        .reset(reset),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .input_data(input_data),
        .frame_done(frame_done),
        .frame_ack(frame_ack),
        .word_count(word_count),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
`ifdef FC_ARGMAX_EN
        ,
        .argmax_idx(argmax_idx),
        .argmax_val(argmax_val)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_wc[$];
    int exp_ai[$];
    int exp_av[$];
    int exp_rd[$];
    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;
    logic fd_prev = 1'b0;
    int fa[6] = '{5, -3, 12, 12, 0, -7};

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic send_word(input int d);
        input_valid = 1'b1;
        input_data  = d[T-1:0];
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        rd_req      = 1'b0;
    endtask

    task automatic push_frame(input int ai, input int av);
        exp_wc.push_back(M);
        exp_ai.push_back(ai);
        exp_av.push_back(av);
    endtask

    task automatic rd(input int a, input int e);
        rd_addr = a[A-1:0];
        rd_req  = 1'b1;
        exp_rd.push_back(e);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
    endtask

    always @(posedge clk) rd_pend <= rd_req;

    // Monitor: frame completion and read responses.
    always @(negedge clk) begin
        if (frame_done && !fd_prev) begin
            if (exp_wc.size() == 0) begin
                chk("unexpected_frame", 1, 0);
            end else begin
                chk("frame_wc", word_count, exp_wc.pop_front());
`ifdef FC_ARGMAX_EN
                chk("argmax_idx", argmax_idx, exp_ai.pop_front());
                chk("argmax_val", argmax_val, exp_av.pop_front());
`endif
            end
        end
        fd_prev = frame_done;
        if (rd_pend) begin
            if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
            else chk("rd_data", rd_data, exp_rd.pop_front());
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", input_ready, 1);
        chk("rst_done", frame_done, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_rd", rd_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(3, 0);

        // Contiguous frame
        push_frame(2, 12);
        for (int i = 0; i < 6; i++) begin
            send_word(fa[i]);
            if (i == 4) chk("fd_early", frame_done, 0);
        end
        chk("fd_after6", frame_done, 1);
        chk("wc_full", word_count, 6);
        chk("ready_hold", input_ready, 0);
        for (int i = 0; i < 6; i++) rd(i, fa[i]);
        rd(7, 0);

        // Valid held high during HOLD, then ack with valid still high
        input_valid = 1'b1;
        input_data  = 20'sd99;
        rd(0, 5);
        repeat (9) @(posedge clk);
        #1;
        chk("ready_hold2", input_ready, 0);
        chk("wc_frozen", word_count, 6);
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        chk("wc_ack", word_count, 0);
        chk("fd_ack", frame_done, 0);
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        chk("wc_99", word_count, 1);
        rd(0, 99);
        rd(1, -3);
        ack();
        chk("wc_ack_collect", word_count, 1);
        chk("fd_ack_collect", frame_done, 0);

        // Reset mid-frame
        send_word(1);
        send_word(2);
        send_word(3);
        chk("wc_4", word_count, 4);
        reset = 1'b0;
        #2;
        chk("wc_async_rst", word_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(2, 0);
        push_frame(0, -1);
        for (int i = 0; i < 6; i++) send_word(-(i + 1));
        chk("fd_neg", frame_done, 1);
        for (int i = 0; i < 6; i++) rd(i, -(i + 1));
        ack();

        // Gapped frame, with read-before-write on index 0
        push_frame(2, 12);
        rd_addr = '0;
        rd_req  = 1'b1;
        exp_rd.push_back(-1);
        for (int i = 0; i < 6; i++) begin
            send_word(fa[i]);
            if (i == 1) begin
                repeat (3) @(posedge clk);
                #1;
                chk("wc_gap", word_count, 2);
                chk("fd_gap", frame_done, 0);
            end
            if (i == 4) chk("fd_gap_early", frame_done, 0);
        end
        chk("fd_gap_after6", frame_done, 1);
        for (int i = 0; i < 6; i++) rd(i, fa[i]);
        ack();

        // All-negative frame with the most negative value last
        push_frame(0, -1);
        for (int i = 0; i < 5; i++) send_word(-1);
        send_word(-524288);
        rd(5, -524288);
        rd(0, -1);
        ack();
        chk("fd_final_ack", frame_done, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("frames_left", exp_wc.size(), 0);
        chk("reads_left", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
